// File: rtl/operand_fetch_pkg.sv
// Shared instruction-field decode for operand fetch and write-back, so both
// ends of the pipeline agree on which registers an instruction reads and writes.
package operand_fetch_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int AW_DEF     = 3;
   localparam int INSTR_W    = 16;

   localparam int OP1_MSB = 15;
   localparam int OP1_LSB = 14;
   localparam int RA_MSB  = 13;
   localparam int RA_LSB  = 11;
   localparam int RB_MSB  = 10;
   localparam int RB_LSB  = 8;
   localparam int OP3_MSB = 7;
   localparam int OP3_LSB = 4;

   typedef enum logic [1:0] {
      OP1_LD  = 2'b00,
      OP1_ST  = 2'b01,
      OP1_IMM = 2'b10,
      OP1_ALU = 2'b11
   } op1_e;

   function automatic op1_e get_op1(input logic [INSTR_W-1:0] instr);
      return op1_e'(instr[OP1_MSB:OP1_LSB]);
   endfunction

   function automatic logic [2:0] get_ra(input logic [INSTR_W-1:0] instr);
      return instr[RA_MSB:RA_LSB];
   endfunction

   function automatic logic [2:0] get_rb(input logic [INSTR_W-1:0] instr);
      return instr[RB_MSB:RB_LSB];
   endfunction

   function automatic logic [3:0] get_op3(input logic [INSTR_W-1:0] instr);
      return instr[OP3_MSB:OP3_LSB];
   endfunction

   function automatic logic op3_no_write(input logic [3:0] op3);
      return (op3 == 4'd7) || (op3 == 4'd13) || (op3 == 4'd14) || (op3 == 4'd15);
   endfunction

   // op2 shares the Ra field position
   function automatic logic op2_writes(input logic [2:0] op2);
      return (op2 == 3'b000) || (op2 == 3'b001) || (op2 == 3'b010);
   endfunction

   function automatic logic uses_ra(input logic [INSTR_W-1:0] instr);
      op1_e op1;
      op1 = get_op1(instr);
      return (op1 == OP1_ALU) || (op1 == OP1_ST);
   endfunction

   function automatic logic uses_rb(input logic [INSTR_W-1:0] instr);
      op1_e       op1;
      logic [2:0] op2;
      op1 = get_op1(instr);
      op2 = get_ra(instr);
      if (op1 == OP1_IMM)
         return (op2 == 3'b001) || (op2 == 3'b010);
      return 1'b1;
   endfunction

   function automatic logic dest_we(input logic [INSTR_W-1:0] instr);
      logic r;
      r = 1'b0;
      case (get_op1(instr))
         OP1_LD:  r = 1'b1;
         OP1_ALU: r = !op3_no_write(get_op3(instr));
         OP1_IMM: r = op2_writes(get_ra(instr));
         default: r = 1'b0;
      endcase
      return r;
   endfunction

   function automatic logic [2:0] dest_addr(input logic [INSTR_W-1:0] instr);
      return (get_op1(instr) == OP1_LD) ? get_ra(instr) : get_rb(instr);
   endfunction

endpackage

// File: rtl/operand_fetch_reg_file_2r1w.sv
// 8-entry register file: one synchronous write port, two combinational reads.
module reg_file_2r1w #(
   parameter int DATA_W = 16,
   parameter int AW     = 3
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              i_we,
   input  logic [AW-1:0]     i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [AW-1:0]     i_raddr_a,
   input  logic [AW-1:0]     i_raddr_b,
   output logic [DATA_W-1:0] o_rdata_a,
   output logic [DATA_W-1:0] o_rdata_b
);

   localparam int DEPTH = 1 << AW;

   logic [DATA_W-1:0] r_mem [DEPTH];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata_a = r_mem[i_raddr_a];
   assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: decodes sources, reads the register file with write-back
// bypass, tracks pending writes, and hands a registered bundle to execute.
module operand_fetch
   import operand_fetch_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int AW     = AW_DEF
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [15:0]       in_instr,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [15:0]       out_instr,
   output logic [DATA_W-1:0] op_a,
   output logic [DATA_W-1:0] op_b,
   output logic [AW-1:0]     out_rd,
   output logic              out_we
);

   localparam int NREG = 1 << AW;

   logic [NREG-1:0]   r_pending;
   logic [NREG-1:0]   w_pending_nxt;
   logic [AW-1:0]     w_ra;
   logic [AW-1:0]     w_rb;
   logic [AW-1:0]     w_dest;
   logic              w_use_a;
   logic              w_use_b;
   logic              w_dest_we;
   logic [DATA_W-1:0] w_rf_a;
   logic [DATA_W-1:0] w_rf_b;
   logic [DATA_W-1:0] w_opnd_a;
   logic [DATA_W-1:0] w_opnd_b;
   logic              w_hit_a;
   logic              w_hit_b;
   logic              w_hit_d;
   logic              w_stall;
   logic              w_issue;

   assign w_ra      = get_ra(in_instr);
   assign w_rb      = get_rb(in_instr);
   assign w_dest    = dest_addr(in_instr);
   assign w_use_a   = uses_ra(in_instr);
   assign w_use_b   = uses_rb(in_instr);
   assign w_dest_we = dest_we(in_instr);

   reg_file_2r1w #(.DATA_W(DATA_W), .AW(AW)) u_rf (
      .clock     (clock),
      .reset_n   (reset_n),
      .i_we      (wr_en),
      .i_waddr   (wr_addr),
      .i_wdata   (wr_data),
      .i_raddr_a (w_ra),
      .i_raddr_b (w_rb),
      .o_rdata_a (w_rf_a),
      .o_rdata_b (w_rf_b)
   );

   assign w_hit_a  = wr_en && (wr_addr == w_ra);
   assign w_hit_b  = wr_en && (wr_addr == w_rb);
   assign w_hit_d  = wr_en && (wr_addr == w_dest);
   assign w_opnd_a = w_hit_a ? wr_data : w_rf_a;
   assign w_opnd_b = w_hit_b ? wr_data : w_rf_b;

   // A pending register being written this cycle is resolved by the bypass
   assign w_stall = (w_use_a   && r_pending[w_ra]   && !w_hit_a) ||
                    (w_use_b   && r_pending[w_rb]   && !w_hit_b) ||
                    (w_dest_we && r_pending[w_dest] && !w_hit_d);

   assign in_ready = !w_stall && (!out_valid || out_ready);
   assign w_issue  = in_valid && in_ready;

   // Set by issue is applied after the clear so it wins on a collision
   always_comb begin
      w_pending_nxt = r_pending;
      if (wr_en) w_pending_nxt[wr_addr] = 1'b0;
      if (w_issue && w_dest_we) w_pending_nxt[w_dest] = 1'b1;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_pending <= '0;
         out_valid <= 1'b0;
         out_instr <= '0;
         op_a      <= '0;
         op_b      <= '0;
         out_rd    <= '0;
         out_we    <= 1'b0;
      end else begin
         r_pending <= w_pending_nxt;
         if (w_issue) begin
            out_valid <= 1'b1;
            out_instr <= in_instr;
            op_a      <= w_opnd_a;
            op_b      <= w_opnd_b;
            out_rd    <= w_dest;
            out_we    <= w_dest_we;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: table of per-cycle vectors plus an
// asynchronous mid-stall reset sequence.
module tb_operand_fetch;

   logic        clock;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_instr;
   logic        wr_en;
   logic [2:0]  wr_addr;
   logic [15:0] wr_data;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_instr;
   logic [15:0] op_a;
   logic [15:0] op_b;
   logic [2:0]  out_rd;
   logic        out_we;

   operand_fetch #(.DATA_W(16), .AW(3)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_instr  (in_instr),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_instr (out_instr),
      .op_a      (op_a),
      .op_b      (op_b),
      .out_rd    (out_rd),
      .out_we    (out_we)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic        iv;
      logic [15:0] instr;
      logic        we;
      logic [2:0]  wa;
      logic [15:0] wd;
      logic        ordy;
      logic        x_ir;
      logic        x_v;
      logic [15:0] x_a;
      logic [15:0] x_b;
      logic [2:0]  x_rd;
      logic        x_we;
      logic [7:0]  x_pend;
   } vec_t;

   vec_t        vecs [20];
   int          n_vec  = 0;
   int          n_fail = 0;
   logic [15:0] exp_instr;

   function automatic logic [15:0] mk(input logic [1:0] op1, input logic [2:0] ra,
                                      input logic [2:0] rb, input logic [3:0] op3);
      return {op1, ra, rb, op3, 4'h0};
   endfunction

   function automatic vec_t v(input logic iv, input logic [15:0] instr, input logic we,
                              input logic [2:0] wa, input logic [15:0] wd, input logic ordy,
                              input logic x_ir, input logic x_v, input logic [15:0] x_a,
                              input logic [15:0] x_b, input logic [2:0] x_rd,
                              input logic x_we, input logic [7:0] x_pend);
      vec_t r;
      r.iv = iv; r.instr = instr; r.we = we; r.wa = wa; r.wd = wd; r.ordy = ordy;
      r.x_ir = x_ir; r.x_v = x_v; r.x_a = x_a; r.x_b = x_b; r.x_rd = x_rd;
      r.x_we = x_we; r.x_pend = x_pend;
      return r;
   endfunction

   task automatic chk(input string name, input int idx, input logic [15:0] act,
                      input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
      end
   endtask

   task automatic apply(input int idx, input vec_t t);
      @(negedge clock);
      in_valid  = t.iv;
      in_instr  = t.instr;
      wr_en     = t.we;
      wr_addr   = t.wa;
      wr_data   = t.wd;
      out_ready = t.ordy;
      #1;
      chk("in_ready", idx, {15'b0, in_ready}, {15'b0, t.x_ir});
      if (t.iv && t.x_ir) exp_instr = t.instr;
      @(posedge clock);
      #1;
      chk("out_valid", idx, {15'b0, out_valid}, {15'b0, t.x_v});
      chk("out_instr", idx, out_instr, exp_instr);
      chk("op_a", idx, op_a, t.x_a);
      chk("op_b", idx, op_b, t.x_b);
      chk("out_rd", idx, {13'b0, out_rd}, {13'b0, t.x_rd});
      chk("out_we", idx, {15'b0, out_we}, {15'b0, t.x_we});
      chk("pending", idx, {8'b0, dut.r_pending}, {8'b0, t.x_pend});
   endtask

   initial begin
      //            iv instr               we wa wd        ordy ir v  a         b         rd we pend
      vecs[0]  = v(1, mk(2'b11,1,2,0),   0, 0, 16'h0000, 1,   1, 1, 16'h0000, 16'h0000, 2, 1, 8'h04);
      vecs[1]  = v(0, 16'h0000,          1, 3, 16'h1234, 1,   1, 0, 16'h0000, 16'h0000, 2, 1, 8'h04);
      vecs[2]  = v(1, mk(2'b01,3,0,0),   0, 0, 16'h0000, 1,   1, 1, 16'h1234, 16'h0000, 0, 0, 8'h04);
      vecs[3]  = v(0, 16'h0000,          1, 2, 16'h0055, 1,   1, 0, 16'h1234, 16'h0000, 0, 0, 8'h00);
      vecs[4]  = v(1, mk(2'b00,1,4,0),   0, 0, 16'h0000, 1,   1, 1, 16'h0000, 16'h0000, 1, 1, 8'h02);
      vecs[5]  = v(1, mk(2'b11,1,2,7),   0, 0, 16'h0000, 1,   0, 0, 16'h0000, 16'h0000, 1, 1, 8'h02);
      vecs[6]  = v(1, mk(2'b11,1,2,7),   1, 1, 16'h00AA, 1,   1, 1, 16'h00AA, 16'h0055, 2, 0, 8'h00);
      vecs[7]  = v(1, mk(2'b00,5,6,0),   0, 0, 16'h0000, 0,   0, 1, 16'h00AA, 16'h0055, 2, 0, 8'h00);
      vecs[8]  = v(1, mk(2'b00,5,6,0),   0, 0, 16'h0000, 0,   0, 1, 16'h00AA, 16'h0055, 2, 0, 8'h00);
      vecs[9]  = v(1, mk(2'b00,5,6,0),   0, 0, 16'h0000, 0,   0, 1, 16'h00AA, 16'h0055, 2, 0, 8'h00);
      vecs[10] = v(1, mk(2'b00,5,6,0),   0, 0, 16'h0000, 1,   1, 1, 16'h0000, 16'h0000, 5, 1, 8'h20);
      vecs[11] = v(1, mk(2'b01,3,1,0),   0, 0, 16'h0000, 1,   1, 1, 16'h1234, 16'h00AA, 1, 0, 8'h20);
      vecs[12] = v(1, mk(2'b11,0,2,0),   0, 0, 16'h0000, 1,   1, 1, 16'h0000, 16'h0055, 2, 1, 8'h24);
      vecs[13] = v(1, mk(2'b10,0,2,0),   1, 2, 16'h0777, 1,   1, 1, 16'h0000, 16'h0777, 2, 1, 8'h24);
      vecs[14] = v(1, mk(2'b00,5,0,0),   0, 0, 16'h0000, 1,   0, 0, 16'h0000, 16'h0777, 2, 1, 8'h24);
      vecs[15] = v(0, 16'h0000,          1, 5, 16'h0005, 1,   1, 0, 16'h0000, 16'h0777, 2, 1, 8'h04);
      vecs[16] = v(0, 16'h0000,          1, 2, 16'h0777, 1,   1, 0, 16'h0000, 16'h0777, 2, 1, 8'h00);
      vecs[17] = v(1, mk(2'b11,3,1,0),   0, 0, 16'h0000, 1,   1, 1, 16'h1234, 16'h00AA, 1, 1, 8'h02);
      vecs[18] = v(1, mk(2'b11,3,2,0),   0, 0, 16'h0000, 1,   1, 1, 16'h1234, 16'h0777, 2, 1, 8'h06);
      vecs[19] = v(1, mk(2'b11,1,0,0),   0, 0, 16'h0000, 0,   0, 1, 16'h1234, 16'h0777, 2, 1, 8'h06);

      reset_n   = 1'b0;
      in_valid  = 1'b0;
      in_instr  = '0;
      wr_en     = 1'b0;
      wr_addr   = '0;
      wr_data   = '0;
      out_ready = 1'b1;
      exp_instr = '0;
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      #1;
      chk("rst_out_valid", -1, {15'b0, out_valid}, 16'h0000);
      chk("rst_op_a", -1, op_a, 16'h0000);
      chk("rst_pending", -1, {8'b0, dut.r_pending}, 16'h0000);
      chk("rst_in_ready", -1, {15'b0, in_ready}, 16'h0001);

      for (int i = 0; i < 20; i++) apply(i, vecs[i]);

      // Asynchronous reset mid-stall: bundle valid, pending = 0x06
      @(negedge clock);
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_out_valid", 20, {15'b0, out_valid}, 16'h0000);
      chk("arst_op_a", 20, op_a, 16'h0000);
      chk("arst_op_b", 20, op_b, 16'h0000);
      chk("arst_out_instr", 20, out_instr, 16'h0000);
      chk("arst_rd_we", 20, {12'b0, out_rd, out_we}, 16'h0000);
      chk("arst_pending", 20, {8'b0, dut.r_pending}, 16'h0000);
      chk("arst_r1", 20, dut.u_rf.r_mem[1], 16'h0000);
      chk("arst_r2", 20, dut.u_rf.r_mem[2], 16'h0000);
      chk("arst_r3", 20, dut.u_rf.r_mem[3], 16'h0000);
      @(negedge clock);
      reset_n  = 1'b1;
      in_valid = 1'b0;
      @(posedge clock);
      #1;
      chk("post_rst_valid", 21, {15'b0, out_valid}, 16'h0000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Read-side counterpart of the write-back address/enable stage: decodes the 16-bit instruction's source fields and reads operands from the 8-entry register file.
- Owns the register file: the write port is driven by the write-back stage (write address + write order + data); two read ports are used here.
- Keeps a pending-write scoreboard, stalls issue on RAW/WAW hazards, bypasses same-cycle write data, and presents operands through one registered valid/ready stage to execute.

Parameters:
DATA_W, 16, register and operand width
AW, 3, register address width (fixed 8 registers; other values unsupported)

Ports:
clock  in  1  sole clock, all state updates on posedge
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  instruction available from decode
in_ready  out  1  this block accepts the instruction this cycle
in_instr  in  16  [15:14]=op1, [13:11]=Ra/op2, [10:8]=Rd/Rb, [7:4]=op3, [3:0]=d
wr_en  in  1  write order from the write-back stage
wr_addr  in  AW  write address from the write-back stage
wr_data  in  DATA_W  write-back data
out_valid  out  1  operand bundle valid
out_ready  in  1  execute consumes the bundle
out_instr  out  16  issued instruction
op_a  out  DATA_W  value of register [13:11]
op_b  out  DATA_W  value of register [10:8]
out_rd  out  AW  destination register of the issued instruction
out_we  out  1  issued instruction will write out_rd

Behaviour:
- Reset (async, reset_n=0): all 8 registers = 0, pending[7:0] = 0, out_valid = 0, and out_instr/op_a/op_b/out_rd/out_we = 0. Release is synchronous to the next posedge.
- Register file: on posedge with wr_en=1, reg[wr_addr] <= wr_data. This happens independent of handshake state.
- Source decode:
  - op1=11: reads Ra and Rb.
  - op1=01: reads Ra and Rb.
  - op1=00: reads Rb.
  - op1=10 with op2 in {001,010}: reads Rb.
  - op1=10 otherwise: no reads.
  - Unused source fields are still read, but never cause a stall.
- Destination decode (out_we):
  - op1=00: write Ra.
  - op1=11: write Rb for op3 not in {7,13,14,15}.
  - op1=10: write Rb for op2 in {000,001,010}.
  - op1=01: no write.
- Bypass: if wr_en=1 and wr_addr equals a source index in the same cycle, the captured operand is wr_data, not the stale array value.
- Hazard:
  - stall = any used source s with pending[s]=1 and not (wr_en && wr_addr==s).
  - Also stall if out_we and the destination is pending and not being written this cycle.
- in_ready = !stall && (!out_valid || out_ready). Combinational; must not depend on in_valid.
- Issue = in_valid && in_ready. At the posedge it loads out_instr/op_a/op_b/out_rd/out_we, sets out_valid=1, and sets pending[dest] if out_we.
- out_valid clears on out_ready with no issue. It stays asserted and the outputs hold while out_ready=0.
- Scoreboard: wr_en clears pending[wr_addr]. If the same register is set by issue and cleared by wr_en in the same cycle, the set wins. A write to a non-pending register only updates the array.
- Latency: 1 cycle from issue to out_valid; full throughput with no hazards.
- Mid-operation reset drops any bundle and clears all pending bits. No partial writes are retained beyond completed posedges.

Decomposition:
- Shared package: op1 encodings (LD=00, ST=01, IMM/BR=10, ALU=11), op3 no-write set {7,13,14,15}, op2 write set {000,001,010}, field bit positions, AW/DATA_W defaults.
- The same package functions (uses_ra, uses_rb, dest_we, dest_addr) must be reused by the write-back stage so both ends agree.
- One sub-module: reg_file_2r1w (8xDATA_W array, async-reset, two combinational reads, one write).

Test Plan:
- Reset, then issue ADD (op1=11, Ra=1, Rb=2) -> op_a=0, op_b=0, out_we=1, out_rd=2, pending=8'b0000_0100 after one cycle.
- Write r3=0x1234 via wr_en, then issue ST reading Ra=3 next cycle -> op_a=0x1234, pending unchanged.
- Issue LD writing r1, then ALU reading r1 -> in_ready=0 until wr_en with wr_addr=1, wr_data=0x00AA arrives. In that cycle in_ready=1 and the captured op_a=0x00AA (bypass).
- Hold out_ready=0 for 3 cycles with in_valid=1 -> out_valid stays 1, outputs stable, in_ready=0. On release, back-to-back issue at 1 per cycle.
- Same cycle: wr_en clears r2 while an issue targets r2 -> pending[2]=1 afterwards.
- Assert reset_n=0 mid-stall with out_valid=1 and pending=0x06 -> all outputs 0, pending 0, registers 0 immediately (asynchronously).
